// File: rtl/interval_timer_bank.sv
// Bank of NCH 6530-style interval timers on an 8-bit register bus.
// Each channel has a prescaler, reload, W1C status flag and per-channel irq.
module interval_timer_bank #(
  parameter  int NCH = 2,
  parameter  int DW  = 8,
  localparam int AW  = $clog2(NCH) + 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cs,
  input  logic           we_n,
  input  logic [AW-1:0]  A,
  input  logic [DW-1:0]  DI,
  output logic [DW-1:0]  DO,
  output logic           OE,
  output logic           irq_n,
  output logic [NCH-1:0] irq_vec
);

  localparam logic [1:0] OFF_COUNT  = 2'd0;
  localparam logic [1:0] OFF_CTRL   = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_RELOAD = 2'd3;

  logic [DW-1:0]  r_count  [NCH];
  logic [DW-1:0]  r_reload [NCH];
  logic [5:0]     r_ctrl   [NCH];
  logic [9:0]     r_pre    [NCH];
  logic [NCH-1:0] r_flag;
  logic [NCH-1:0] r_fast;
  logic [DW-1:0]  r_do;
  logic           r_oe;
  logic           r_irq_n;
  logic [NCH-1:0] r_irq_vec;

  logic [3:0]     w_ch;
  logic [1:0]     w_off;
  logic           w_ch_ok;
  logic           w_rd;
  logic           w_wr;
  logic [NCH-1:0] w_sel;
  logic [9:0]     w_div_m1 [NCH];
  logic [NCH-1:0] w_tick;
  logic [NCH-1:0] w_uflow;
  logic [NCH-1:0] w_clr;
  logic [NCH-1:0] w_irq;
  logic [DW-1:0]  w_rdata;

  assign w_ch    = 4'(A >> 2);
  assign w_off   = A[1:0];
  assign w_ch_ok = (32'(w_ch) < NCH);
  assign w_rd    = cs & we_n;
  assign w_wr    = cs & ~we_n & w_ch_ok;

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      w_sel[i] = w_ch_ok && (w_ch == 4'(i));
      case (r_ctrl[i][1:0])
        2'd0:    w_div_m1[i] = 10'd0;
        2'd1:    w_div_m1[i] = 10'd7;
        2'd2:    w_div_m1[i] = 10'd63;
        default: w_div_m1[i] = 10'd1023;
      endcase
      // fast mode (after a one-shot underflow) forces divide-by-1
      if (r_fast[i]) w_div_m1[i] = 10'd0;
      w_tick[i]  = r_ctrl[i][4] && (r_pre[i] == w_div_m1[i]);
      w_uflow[i] = w_tick[i] && (r_count[i] == '0);
      w_clr[i]   = w_sel[i] && cs &&
                   ((!we_n && w_off == OFF_STATUS && DI[0]) ||
                    (we_n && w_off == OFF_COUNT && r_ctrl[i][5]));
      w_irq[i]   = r_flag[i] & r_ctrl[i][2];
      if (w_sel[i]) begin
        case (w_off)
          OFF_COUNT:  w_rdata = r_count[i];
          OFF_CTRL:   w_rdata = DW'(r_ctrl[i]);
          OFF_STATUS: w_rdata = DW'(r_flag[i]);
          default:    w_rdata = r_reload[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_count[i]  <= '0;
        r_reload[i] <= '0;
        r_ctrl[i]   <= '0;
        r_pre[i]    <= '0;
      end
      r_flag    <= '0;
      r_fast    <= '0;
      r_do      <= '0;
      r_oe      <= 1'b0;
      r_irq_n   <= 1'b1;
      r_irq_vec <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (r_ctrl[i][4]) begin
          r_pre[i] <= w_tick[i] ? 10'd0 : r_pre[i] + 10'd1;
          if (w_tick[i]) begin
            if (r_count[i] != '0) begin
              r_count[i] <= r_count[i] - DW'(1);
            end else if (r_ctrl[i][3]) begin
              r_count[i] <= r_reload[i];
            end else begin
              r_count[i] <= '1;
              r_fast[i]  <= 1'b1;
            end
          end
        end
        // an underflow in the same cycle beats any clear request
        if (w_uflow[i])     r_flag[i] <= 1'b1;
        else if (w_clr[i])  r_flag[i] <= 1'b0;
        if (w_wr && w_sel[i]) begin
          case (w_off)
            OFF_COUNT: begin
              r_count[i] <= DI;
              r_pre[i]   <= '0;
              r_flag[i]  <= 1'b0;
              r_fast[i]  <= 1'b0;
            end
            OFF_CTRL: begin
              r_ctrl[i] <= DI[5:0];
              r_fast[i] <= 1'b0;
            end
            OFF_RELOAD: r_reload[i] <= DI;
            default: ;
          endcase
        end
      end
      r_oe <= w_rd;
      if (w_rd) r_do <= w_rdata;
      r_irq_vec <= w_irq;
      r_irq_n   <= ~|w_irq;
    end
  end

  assign DO      = r_do;
  assign OE      = r_oe;
  assign irq_n   = r_irq_n;
  assign irq_vec = r_irq_vec;

endmodule

// File: tb/tb_interval_timer_bank.sv
// Bench for interval_timer_bank: directed scenarios plus random bus traffic,
// every cycle compared against a behavioural model of the timer bank.
module tb_interval_timer_bank;
  localparam int NCH  = 2;
  localparam int DW   = 8;
  localparam int AW   = $clog2(NCH) + 2;
  localparam int MAXC = (1 << DW) - 1;

  logic           clk = 1'b0;
  logic           rst_n, cs, we_n;
  logic [AW-1:0]  A;
  logic [DW-1:0]  DI;
  logic [DW-1:0]  DO;
  logic           OE, irq_n;
  logic [NCH-1:0] irq_vec;

  int n_checks = 0;
  int n_errors = 0;

  interval_timer_bank #(.NCH(NCH), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we_n(we_n), .A(A), .DI(DI),
    .DO(DO), .OE(OE), .irq_n(irq_n), .irq_vec(irq_vec)
  );

  always #5 clk = ~clk;

  // behavioural model state
  int m_cnt [NCH];
  int m_rel [NCH];
  int m_ctl [NCH];
  int m_flag[NCH];
  int m_pre [NCH];
  int m_fast[NCH];
  int m_do, m_oe, m_irqn, m_irqv;
  int divtab[4] = '{1, 8, 64, 1024};

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit c, input bit rd, input int a, input int d);
    int ch, off, rdata, irqv;
    ch = a / 4;
    off = a % 4;
    if (!r) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] = 0; m_rel[i] = 0; m_ctl[i] = 0;
        m_flag[i] = 0; m_pre[i] = 0; m_fast[i] = 0;
      end
      m_do = 0; m_oe = 0; m_irqn = 1; m_irqv = 0;
      return;
    end
    irqv = 0;
    for (int i = 0; i < NCH; i++)
      if (m_flag[i] != 0 && ((m_ctl[i] >> 2) & 1) != 0) irqv |= (1 << i);
    rdata = 0;
    if (ch < NCH) begin
      case (off)
        0: rdata = m_cnt[ch];
        1: rdata = m_ctl[ch];
        2: rdata = m_flag[ch];
        default: rdata = m_rel[ch];
      endcase
    end
    for (int i = 0; i < NCH; i++) begin
      bit uf, clr;
      int dv;
      uf = 0;
      clr = 0;
      if (((m_ctl[i] >> 4) & 1) != 0) begin
        dv = (m_fast[i] != 0) ? 1 : divtab[m_ctl[i] & 3];
        if (m_pre[i] == dv - 1) begin
          m_pre[i] = 0;
          if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
          else begin
            uf = 1;
            if (((m_ctl[i] >> 3) & 1) != 0) m_cnt[i] = m_rel[i];
            else begin
              m_cnt[i] = MAXC;
              m_fast[i] = 1;
            end
          end
        end else m_pre[i] = (m_pre[i] + 1) % 1024;
      end
      if (c && ch == i) begin
        if (!rd && off == 2 && (d & 1) != 0) clr = 1;
        if (rd && off == 0 && ((m_ctl[i] >> 5) & 1) != 0) clr = 1;
      end
      if (uf) m_flag[i] = 1;
      else if (clr) m_flag[i] = 0;
      if (c && !rd && ch == i) begin
        case (off)
          0: begin m_cnt[i] = d & MAXC; m_pre[i] = 0; m_flag[i] = 0; m_fast[i] = 0; end
          1: begin m_ctl[i] = d & 63; m_fast[i] = 0; end
          3: m_rel[i] = d & MAXC;
          default: ;
        endcase
      end
    end
    m_oe = (c && rd) ? 1 : 0;
    if (m_oe != 0) m_do = rdata;
    m_irqv = irqv;
    m_irqn = (irqv == 0) ? 1 : 0;
  endtask

  task automatic cycle(input bit r, input bit c, input bit rd, input int a, input int d);
    rst_n = r; cs = c; we_n = rd; A = AW'(a); DI = DW'(d);
    @(posedge clk);
    model_step(r, c, rd, a, d);
    #1;
    chk_eq("OE", 32'(OE), 32'(m_oe));
    chk_eq("DO", 32'(DO), 32'(m_do));
    chk_eq("irq_n", 32'(irq_n), 32'(m_irqn));
    chk_eq("irq_vec", 32'(irq_vec), 32'(m_irqv));
  endtask

  task automatic wr(input int ch, input int off, input int d);
    cycle(1'b1, 1'b1, 1'b0, ch * 4 + off, d);
  endtask

  task automatic rd(input int ch, input int off);
    cycle(1'b1, 1'b1, 1'b1, ch * 4 + off, int'($urandom_range(0, MAXC)));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      cycle(1'b1, 1'b0, 1'($urandom), int'($urandom_range(0, 4 * NCH - 1)),
            int'($urandom_range(0, MAXC)));
  endtask

  int exp_seq[6] = '{2, 1, 0, 2, 1, 0};

  initial begin
    // reset with inputs toggling
    for (int k = 0; k < 4; k++)
      cycle(1'b0, 1'($urandom), 1'($urandom), int'($urandom_range(0, 4 * NCH - 1)),
            int'($urandom_range(0, MAXC)));
    chk_eq("rst_irq_n", 32'(irq_n), 32'd1);
    chk_eq("rst_irq_vec", 32'(irq_vec), 32'd0);
    chk_eq("rst_oe", 32'(OE), 32'd0);
    chk_eq("rst_do", 32'(DO), 32'd0);
    for (int ch = 0; ch < NCH; ch++)
      for (int off = 0; off < 4; off++) begin
        rd(ch, off);
        chk_eq("rst_reg", 32'(DO), 32'd0);
      end

    // one-shot, divide by 1
    wr(0, 1, 'h14);
    wr(0, 0, 3);
    idle(5);
    chk_eq("oneshot_irq_n", 32'(irq_n), 32'd0);
    chk_eq("oneshot_irq_vec", 32'(irq_vec), 32'd1);
    wr(0, 2, 1);
    idle(1);
    chk_eq("w1c_irq_n", 32'(irq_n), 32'd1);

    // divide by 8, then fast mode after underflow
    wr(0, 1, 'h11);
    wr(0, 0, 3);
    idle(31);
    rd(0, 0);
    chk_eq("div8_zero", 32'(DO), 32'd0);
    rd(0, 0);
    chk_eq("div8_wrap", 32'(DO), 32'(MAXC));
    rd(0, 0);
    chk_eq("div8_fast", 32'(DO), 32'(MAXC - 1));
    wr(0, 0, 5);
    idle(20);

    // auto-reload on channel 1
    wr(1, 3, 2);
    wr(1, 1, 'h1C);
    wr(1, 0, 2);
    for (int k = 0; k < 6; k++) begin
      rd(1, 0);
      chk_eq("reload_seq", 32'(DO), 32'(exp_seq[k]));
    end
    wr(1, 2, 1);
    idle(7);
    wr(1, 1, 0);

    // clear-on-read, and a read in the underflow cycle
    wr(0, 1, 'h34);
    wr(0, 0, 1);
    idle(1);
    rd(0, 0);
    rd(0, 2);
    chk_eq("rdclr_setwins", 32'(DO), 32'd1);
    rd(0, 0);
    rd(0, 2);
    chk_eq("rdclr_cleared", 32'(DO), 32'd0);

    // COUNT write on a tick cycle
    wr(0, 0, 7);
    rd(0, 0);
    chk_eq("wr_vs_tick", 32'(DO), 32'd7);

    // reset mid-interval
    wr(0, 1, 'h14);
    wr(0, 0, 3);
    idle(5);
    cycle(1'b0, 1'b1, 1'b1, 0, 0);
    chk_eq("mid_rst_irq_n", 32'(irq_n), 32'd1);
    chk_eq("mid_rst_irq_vec", 32'(irq_vec), 32'd0);
    chk_eq("mid_rst_oe", 32'(OE), 32'd0);
    idle(10);
    rd(0, 0);
    chk_eq("mid_rst_stopped", 32'(DO), 32'd0);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      bit r, c;
      r = ($urandom_range(0, 499) != 0);
      c = ($urandom_range(0, 2) == 0);
      cycle(r, c, 1'($urandom), int'($urandom_range(0, 4 * NCH - 1)),
            int'($urandom_range(0, MAXC)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
